apb_master_bridge: RTL
======================

# apb_master_bridge

APB3 initiator that turns single-word requests from the core/interconnect side into APB3 transfers toward peripheral slaves, and returns read data or a timeout indication on a response channel. It sits between the SoC system bus and the APB peripheral segment. It drives the master end of the APB3 signal set: PADDR, PSEL, PENABLE, PWRITE and PWDATA out; PREADY and PRDATA in. It handles one outstanding transfer at a time and adds a watchdog on PREADY.

## Interface
Parameters:
- DATA_WIDTH, 32, width of PWDATA/PRDATA and the request/response data.
- ADDR_WIDTH, 32, width of PADDR and req_addr.
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles waiting for PREADY; 0 disables the timeout.

Ports:
- PCLK  in  1  the single clock.
- PRESET  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  bridge accepts the request this cycle.
- req_addr  in  ADDR_WIDTH  target address.
- req_write  in  1  1 = write, 0 = read.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_timeout  out  1  transfer aborted by the watchdog.
- PADDR  out  ADDR_WIDTH  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PREADY  in  1  slave ready.
- PRDATA  in  DATA_WIDTH  slave read data.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr/write/wdata into PADDR/PWRITE/PWDATA and go to SETUP.
- SETUP: PSEL=1, PENABLE=0. Always lasts exactly one cycle, then go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1.
  - On PREADY=1, capture PRDATA into rsp_rdata for reads (0 for writes), clear rsp_timeout, and go to RESP.
  - Otherwise increment the wait counter.
  - When the counter equals TIMEOUT_CYCLES (nonzero) with PREADY still 0: set rsp_timeout=1, rsp_rdata=0, go to RESP.
- RESP:
  - PSEL=0, PENABLE=0, rsp_valid=1.
  - Hold rsp_rdata and rsp_timeout stable until rsp_ready=1, then go to IDLE.
- Wait counter: width $clog2(TIMEOUT_CYCLES+1) (minimum 1). Cleared on entry to ACCESS.
- PADDR/PWRITE/PWDATA:
  - Constant from SETUP through the end of ACCESS.
  - Keep their last value in RESP and IDLE; they change only on request acceptance.
- req_ready is 0 in SETUP, ACCESS and RESP. A requester holding req_valid waits and loses nothing.

## Timing
- Reset values: req_ready=0 while PRESET is asserted, 1 in IDLE after release. All other outputs reset to 0. State resets to IDLE.
- Minimum latency, with acceptance at cycle 0:
  - SETUP at cycle 1.
  - ACCESS at cycle 2 (PREADY=1).
  - rsp_valid at cycle 3.
  - Next acceptance at cycle 4 if rsp_ready=1 at cycle 3.
- Each PREADY=0 cycle in ACCESS adds one cycle.
- Timeout: with TIMEOUT_CYCLES=N, ACCESS lasts exactly N+1 cycles before RESP.
  - The counter is compared before the increment.
  - PREADY=1 in the final cycle wins over timeout: the response is normal.
- PSEL is never asserted in two consecutive transfers without an intervening deassertion.
- PRESET asserted mid-transfer: outputs return to reset values immediately (asynchronously). The transfer is dropped and no response is produced.

## Structure
- Shared package apb_pkg:
  - FSM state enum type.
  - Default DATA_WIDTH/ADDR_WIDTH localparams.
  - Timeout-disabled constant.
- Single module. The watchdog counter is small enough to stay inline; no sub-module.

## Test plan
- Read, zero waits: req addr 0x1000_0004 read, slave PREADY=1, PRDATA=0xDEAD_BEEF. Expect:
  - PSEL cycle 1, PENABLE cycle 2.
  - rsp_valid cycle 3 with rsp_rdata=0xDEAD_BEEF, rsp_timeout=0.
- Write, 3 wait states: req write 0x5A5A_0001 to 0x1000_0010, PREADY low for 3 ACCESS cycles. Expect:
  - PADDR/PWDATA stable for all 4 ACCESS cycles.
  - rsp_valid at cycle 6, rsp_rdata=0.
- Timeout: TIMEOUT_CYCLES=4, PREADY stuck 0. Expect:
  - ACCESS for 5 cycles, then PSEL=0.
  - rsp_timeout=1, rsp_rdata=0.
  - PREADY=1 on the 5th cycle instead gives a normal response.
- Response backpressure: rsp_ready=0 for 5 cycles. Expect:
  - rsp_valid and data held.
  - req_ready=0 throughout; next request accepted only after the rsp handshake.
- Back-to-back requests with req_valid held: expect PSEL low for at least one cycle between transfers and addresses issued in order.
- Reset mid-ACCESS: assert PRESET during ACCESS. Expect:
  - PSEL, PENABLE, rsp_valid = 0 immediately.
  - IDLE after release; a new request completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB3 master bridge.
package apb_pkg;

    // Default bus widths used by the bridge parameters.
    localparam int unsigned APB_DATA_WIDTH = 32;
    localparam int unsigned APB_ADDR_WIDTH = 32;

    // A TIMEOUT_CYCLES value of this turns the PREADY watchdog off.
    localparam int unsigned TIMEOUT_DISABLED = 0;

    // Bridge transfer phases.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2,
        StResp   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/apb_master_bridge.sv
// APB3 initiator: one outstanding single-word transfer at a time, with a
// PREADY watchdog that aborts a stalled ACCESS phase and flags a timeout.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    // Request channel
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_write,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    // Response channel
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_timeout,
    // APB3 master port
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA
);

    // Counter must hold the value TIMEOUT_CYCLES itself; keep at least one bit.
    localparam int unsigned CntWidth =
        (TIMEOUT_CYCLES == TIMEOUT_DISABLED) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(TIMEOUT_CYCLES);
    localparam bit TimeoutEn = (TIMEOUT_CYCLES != TIMEOUT_DISABLED);

    apb_state_e            state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  timeout_q, timeout_d;

    // State and datapath registers; reset returns every output to its idle value.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic: accept, one SETUP cycle, ACCESS with watchdog, hold response.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        rdata_d   = rdata_q;
        timeout_d = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    // APB address/control only move on acceptance.
                    paddr_d  = req_addr;
                    pwrite_d = req_write;
                    pwdata_d = req_wdata;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                cnt_d   = '0;
                state_d = StAccess;
            end
            StAccess: begin
                // PREADY is checked first so a last-cycle ready beats the watchdog.
                if (PREADY) begin
                    rdata_d   = pwrite_q ? '0 : PRDATA;
                    timeout_d = 1'b0;
                    state_d   = StResp;
                end else if (TimeoutEn && (cnt_q == CntMax)) begin
                    rdata_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = StResp;
                end else if (TimeoutEn) begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Phase-decoded outputs; they follow the asynchronously reset state at once.
    always_comb begin
        req_ready   = (state_q == StIdle) && !PRESET;
        PSEL        = (state_q == StSetup) || (state_q == StAccess);
        PENABLE     = (state_q == StAccess);
        rsp_valid   = (state_q == StResp);
        PADDR       = paddr_q;
        PWRITE      = pwrite_q;
        PWDATA      = pwdata_q;
        rsp_rdata   = rdata_q;
        rsp_timeout = timeout_q;
    end

endmodule
